// File: rtl/pad_responder.sv
// Device end of the NES/SNES serial pad protocol (4021-style shift responder).
// Optional watchdog abort in SHIFT is enabled by defining PAD_TIMEOUT_EN.
module pad_responder #(
    parameter bit   SNES_MODE      = 1'b1,
    parameter logic TAIL_LEVEL     = 1'b1,
    parameter int   TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pad_latch,
    input  logic        pad_clk,
    input  logic [11:0] btn_in,
    output logic        pad_data,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [3:0] LAST = SNES_MODE ? 4'd15 : 4'd7;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] snap_q, snap_d;
    logic        pad_data_q, pad_data_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [2:0]  latch_sync_q, latch_sync_d;
    logic [2:0]  clk_sync_q, clk_sync_d;
    logic [15:0] frame_vec;
    logic        latch_hi, latch_fall, clk_rise;
`ifdef PAD_TIMEOUT_EN
    logic [12:0] wdog_q, wdog_d;
`endif

    // [1] is the synchronised level, [2] the previous one for edge detect
    assign latch_hi   = latch_sync_q[1];
    assign latch_fall = ~latch_sync_q[1] & latch_sync_q[2];
    assign clk_rise   = clk_sync_q[1] & ~clk_sync_q[2];

    always_comb begin
        frame_vec    = SNES_MODE ? {4'b0000, btn_in} : {8'h00, btn_in[7:0]};
        latch_sync_d = {latch_sync_q[1:0], pad_latch};
        clk_sync_d   = {clk_sync_q[1:0], pad_clk};
        state_d      = state_q;
        cnt_d        = cnt_q;
        snap_d       = snap_q;
        frame_done_d = 1'b0;
`ifdef PAD_TIMEOUT_EN
        wdog_d       = 13'd0;
`endif
        unique case (state_q)
            IDLE: begin
                if (latch_hi) state_d = LOAD;
            end
            LOAD: begin
                snap_d = frame_vec;
                if (latch_fall) begin
                    state_d = SHIFT;
                    cnt_d   = 4'd0;
                end
            end
            SHIFT: begin
`ifdef PAD_TIMEOUT_EN
                wdog_d = clk_rise ? 13'd0 : wdog_q + 13'd1;
`endif
                if (latch_hi) begin
                    state_d = LOAD;
                end else if (clk_rise) begin
                    // counter parks on the last bit index instead of wrapping
                    if (cnt_q == LAST) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef PAD_TIMEOUT_EN
                else if (wdog_q + 13'd1 == 13'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                end
`endif
            end
            DONE: begin
                if (latch_hi) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == LOAD) || (state_d == SHIFT);
        unique case (state_d)
            LOAD:    pad_data_d = ~frame_vec[0];
            SHIFT:   pad_data_d = ~snap_d[cnt_d];
            default: pad_data_d = TAIL_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            snap_q       <= 16'h0000;
            pad_data_q   <= TAIL_LEVEL;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            latch_sync_q <= 3'b000;
            clk_sync_q   <= 3'b000;
`ifdef PAD_TIMEOUT_EN
            wdog_q       <= 13'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            pad_data_q   <= pad_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            latch_sync_q <= latch_sync_d;
            clk_sync_q   <= clk_sync_d;
`ifdef PAD_TIMEOUT_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign pad_data   = pad_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pad_responder.sv
// Scoreboard bench for pad_responder: SNES and NES instances share host lines.
// Expected serial bits are queued by the host driver and checked by a monitor.
module tb_pad_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pad_latch = 1'b0;
    logic        pad_clk = 1'b0;
    logic [11:0] btn_in = 12'h000;
    logic        pd_s, busy_s, fd_s;
    logic        pd_n, busy_n, fd_n;

    int   n_checks = 0;
    int   n_fail = 0;
    int   fd_cnt_s = 0;
    int   fd_cnt_n = 0;
    bit   sel_nes = 1'b0;
    bit   exp_q[$];
    event sample_ev;

    pad_responder #(.SNES_MODE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .pad_latch(pad_latch), .pad_clk(pad_clk),
        .btn_in(btn_in), .pad_data(pd_s), .busy(busy_s), .frame_done(fd_s)
    );

    pad_responder #(.SNES_MODE(1'b0)) dut_n (
        .clk(clk), .reset(reset), .pad_latch(pad_latch), .pad_clk(pad_clk),
        .btn_in(btn_in), .pad_data(pd_n), .busy(busy_n), .frame_done(fd_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fd_s) fd_cnt_s <= fd_cnt_s + 1;
        if (fd_n) fd_cnt_n <= fd_cnt_n + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every host sample point pops one expected bit
    initial begin
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                chk("serial_underflow", 1, 0);
            end else begin
                chk("serial_bit", int'(sel_nes ? pd_n : pd_s), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_latch();
        pad_latch = 1'b1;
        wait_cyc(6);
        pad_latch = 1'b0;
        wait_cyc(6);
    endtask

    // n host clocks; exp[i] is the line level the host reads before edge i
    task automatic clocks(input int n, input logic [31:0] exp);
        for (int i = 0; i < n; i++) exp_q.push_back(exp[i]);
        for (int i = 0; i < n; i++) begin
            wait_cyc(6);
            -> sample_ev;
            #1 pad_clk = 1'b1;
            wait_cyc(6);
            pad_clk = 1'b0;
        end
    endtask

    initial begin
        wait_cyc(3);
        chk("reset_pad_s", pd_s, 1);
        chk("reset_busy_s", busy_s, 0);
        chk("reset_fd_s", fd_s, 0);
        chk("reset_pad_n", pd_n, 1);
        reset = 1'b0;
        wait_cyc(4);
        chk("idle_pad_s", pd_s, 1);

        // 1: SNES, only B pressed
        btn_in = 12'h001;
        do_latch();
        chk("load_busy_s", busy_s, 1);
        clocks(16, 32'h0000_FFFE);
        wait_cyc(4);
        chk("t1_fd_count", fd_cnt_s, 1);
        chk("t1_tail", pd_s, 1);
        chk("t1_busy_done", busy_s, 0);

        // 2: NES 0xA5 then two extra clocks read the tail level
        sel_nes = 1'b1;
        btn_in  = 12'h0A5;
        do_latch();
        clocks(10, 32'h0000_035A);
        wait_cyc(4);
        chk("t2_fd_count_n", fd_cnt_n, 2);
        chk("t2_tail_n", pd_n, 1);
        sel_nes = 1'b0;

        // 3: partial frame abandoned by a new latch
        btn_in = 12'h021;
        do_latch();
        clocks(5, 32'h0000_001E);
        wait_cyc(4);
        chk("t3_busy_partial", busy_s, 1);
        do_latch();
        chk("t3_no_fd", fd_cnt_s, 1);
        chk("t3_busy_relatch", busy_s, 1);
        clocks(16, 32'h0000_FFDE);
        wait_cyc(4);
        chk("t3_fd_count", fd_cnt_s, 2);

        // 4: snapshot holds after latch falls
        btn_in = 12'h000;
        do_latch();
        btn_in = 12'hFFF;
        clocks(16, 32'h0000_FFFF);
        do_latch();
        clocks(16, 32'h0000_F000);
        wait_cyc(4);
        chk("t4_fd_count", fd_cnt_s, 4);

        // 5: reset mid-shift, following host clocks ignored
        btn_in = 12'h000;
        do_latch();
        clocks(3, 32'h0000_0007);
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        chk("t5_pad", pd_s, 1);
        chk("t5_busy", busy_s, 0);
        clocks(4, 32'h0000_000F);
        wait_cyc(4);
        chk("t5_busy_after", busy_s, 0);
        chk("t5_fd_count", fd_cnt_s, 4);

        // 6: stall after 3 clocks, no watchdog in default build
        btn_in = 12'h008;
        do_latch();
        clocks(3, 32'h0000_0007);
        wait_cyc(70);
        chk("t6_busy", busy_s, 1);
        chk("t6_pad_bit3", pd_s, 0);
        chk("t6_fd_count", fd_cnt_s, 4);

        wait_cyc(2);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
